// File: rtl/ttt_pkg.sv
// Shared types and window-geometry helpers for the sequential tic-tac-toe engine.
package ttt_pkg;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      WIN   = 2'd1,
      BLOCK = 2'd2,
      EMPTY = 2'd3
   } strategy_e;

   typedef enum logic [2:0] {
      IDLE,
      SCAN_WIN,
      SCAN_BLOCK,
      SCAN_EMPTY,
      DONE
   } state_e;

   function automatic int win_count(input int n, input int k);
      int m;
      m = n - k + 1;
      return 2 * n * m + 2 * m * m;
   endfunction

   // Windows: horizontals, verticals, diagonals, anti-diagonals; starts row-major.
   function automatic int window_cell(input int n, input int k, input int idx, input int j);
      int m, r, c, i;
      m = n - k + 1;
      i = idx;
      if (i < n * m) begin
         r = i / m; c = i % m;
         return r * n + c + j;
      end
      i = i - n * m;
      if (i < m * n) begin
         r = i / n; c = i % n;
         return r * n + c + j * n;
      end
      i = i - m * n;
      if (i < m * m) begin
         r = i / m; c = i % m;
         return r * n + c + j * (n + 1);
      end
      i = i - m * m;
      r = i / m; c = i % m + k - 1;
      return r * n + c + j * (n - 1);
   endfunction

endpackage

// File: rtl/ttt_window_eval.sv
// Classifies one K-cell window: near-win for X, near-win for O, and its first empty slot.
module ttt_window_eval
   import ttt_pkg::*;
#(
   parameter int K = 3
) (
   input  logic [K-1:0]         wx,
   input  logic [K-1:0]         wo,
   output logic                 hit_x,
   output logic                 hit_o,
   output logic [$clog2(K)-1:0] epos
);

   localparam int CNTW = $clog2(K + 1);
   localparam int JW   = $clog2(K);

   logic [CNTW-1:0] cx, co;

   always_comb begin
      cx   = '0;
      co   = '0;
      epos = '0;
      for (int unsigned j = K; j > 0; j--) begin
         cx = cx + CNTW'(wx[j-1]);
         co = co + CNTW'(wo[j-1]);
         if (!wx[j-1] && !wo[j-1]) epos = JW'(j - 1);
      end
      hit_x = (cx == CNTW'(K - 1)) && (co == '0);
      hit_o = (co == CNTW'(K - 1)) && (cx == '0);
   end

endmodule

// File: rtl/ttt_seq_engine.sv
// Sequential X move generator: scans one window per cycle for win, then block, then picks an empty cell.
module ttt_seq_engine
   import ttt_pkg::*;
#(
   parameter int N = 3,
   parameter int K = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N*N-1:0] xin,
   input  logic [N*N-1:0] oin,
   output logic           busy,
   output logic           done,
   output logic [N*N-1:0] move,
   output logic [N*N-1:0] next_board,
   output logic [1:0]     strategy,
   output logic           no_move,
   output logic           bad_input
);

   localparam int NC  = N * N;
   localparam int L   = win_count(N, K);
   localparam int IW  = $clog2(L);
   localparam int CW  = $clog2(NC);
   localparam int JW  = $clog2(K);
   localparam int CTR = (N / 2) * N + N / 2;
   localparam logic [IW-1:0] LAST = IW'(L - 1);

   state_e          state;
   logic [IW-1:0]   idx;
   logic [NC-1:0]   xb, ob;
   logic [K-1:0]    wx, wo;
   logic            hit_x, hit_o;
   logic [JW-1:0]   epos;
   logic [NC-1:0]   hmask, emask, free;

   // Gather the current window and the one-hot of its empty cell.
   always_comb begin
      wx    = '0;
      wo    = '0;
      hmask = '0;
      for (int unsigned w = 0; w < L; w++) begin
         if (idx == IW'(w)) begin
            for (int unsigned j = 0; j < K; j++) begin
               wx[j] = xb[CW'(window_cell(N, K, w, j))];
               wo[j] = ob[CW'(window_cell(N, K, w, j))];
               if (epos == JW'(j)) hmask[CW'(window_cell(N, K, w, j))] = 1'b1;
            end
         end
      end
   end

   ttt_window_eval #(.K(K)) u_eval (
      .wx    (wx),
      .wo    (wo),
      .hit_x (hit_x),
      .hit_o (hit_o),
      .epos  (epos)
   );

   // Later assignments win: lowest free, then corners in reverse order, then centre.
   always_comb begin
      free  = ~(xb | ob);
      emask = '0;
      for (int unsigned i = NC; i > 0; i--) begin
         if (free[CW'(i - 1)]) begin
            emask = '0;
            emask[CW'(i - 1)] = 1'b1;
         end
      end
      if (free[CW'(NC - 1)]) begin emask = '0; emask[CW'(NC - 1)] = 1'b1; end
      if (free[CW'(NC - N)]) begin emask = '0; emask[CW'(NC - N)] = 1'b1; end
      if (free[CW'(N - 1)])  begin emask = '0; emask[CW'(N - 1)]  = 1'b1; end
      if (free[0])           begin emask = '0; emask[0]           = 1'b1; end
      if ((N % 2 == 1) && free[CW'(CTR)]) begin emask = '0; emask[CW'(CTR)] = 1'b1; end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         xb         <= '0;
         ob         <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         move       <= '0;
         next_board <= '0;
         strategy   <= NONE;
         no_move    <= 1'b0;
         bad_input  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               xb         <= xin;
               ob         <= oin;
               idx        <= '0;
               busy       <= 1'b1;
               move       <= '0;
               next_board <= xin;
               strategy   <= NONE;
               no_move    <= 1'b0;
               bad_input  <= |(xin & oin);
               state      <= (|(xin & oin)) ? DONE : SCAN_WIN;
            end
            SCAN_WIN: begin
               if (hit_x) begin
                  move       <= hmask;
                  next_board <= xb | hmask;
                  strategy   <= WIN;
                  state      <= DONE;
               end else if (idx == LAST) begin
                  idx   <= '0;
                  state <= SCAN_BLOCK;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            SCAN_BLOCK: begin
               if (hit_o) begin
                  move       <= hmask;
                  next_board <= xb | hmask;
                  strategy   <= BLOCK;
                  state      <= DONE;
               end else if (idx == LAST) begin
                  idx   <= '0;
                  state <= SCAN_EMPTY;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            SCAN_EMPTY: begin
               if (|emask) begin
                  move       <= emask;
                  next_board <= xb | emask;
                  strategy   <= EMPTY;
               end else begin
                  no_move <= 1'b1;
               end
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ttt_seq_engine.sv
// Directed bench for ttt_seq_engine: N=3/K=3 and N=5/K=4 instances, latency and result checks.
module tb_ttt_seq_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start3 = 1'b0, start5 = 1'b0;
   logic [8:0]  x3 = '0, o3 = '0;
   logic [24:0] x5 = '0, o5 = '0;
   logic        busy3, done3, nm3, bi3;
   logic [8:0]  mv3, nb3;
   logic [1:0]  st3;
   logic        busy5, done5, nm5, bi5;
   logic [24:0] mv5, nb5;
   logic [1:0]  st5;

   int total = 0;
   int bad = 0;
   int cyc;
   int dcount;

   always #5 clk = ~clk;

   ttt_seq_engine #(.N(3), .K(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .xin(x3), .oin(o3),
      .busy(busy3), .done(done3), .move(mv3), .next_board(nb3),
      .strategy(st3), .no_move(nm3), .bad_input(bi3)
   );

   ttt_seq_engine #(.N(5), .K(4)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start5), .xin(x5), .oin(o5),
      .busy(busy5), .done(done5), .move(mv5), .next_board(nb5),
      .strategy(st5), .no_move(nm5), .bad_input(bi5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns the index of the rising edge after which done was seen (start edge = 0).
   task automatic run(input bit big, input logic [24:0] x, input logic [24:0] o,
                      input int glitch, output int c);
      @(negedge clk);
      if (big) begin x5 = x; o5 = o; start5 = 1'b1; end
      else begin x3 = x[8:0]; o3 = o[8:0]; start3 = 1'b1; end
      @(posedge clk); #1;
      start3 = 1'b0; start5 = 1'b0;
      c = 0;
      while (c < 100) begin
         @(negedge clk);
         if (big ? done5 : done3) break;
         if (glitch > 0 && c == glitch) begin
            start3 = 1'b1; x3 = 9'h003; o3 = 9'h018;
         end else begin
            start3 = 1'b0;
         end
         @(posedge clk);
         c++;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_move", {23'd0, mv3}, 32'h0);
      check("rst_next", {23'd0, nb3}, 32'h0);
      check("rst_flags", {26'd0, st3, nm3, bi3, done3, busy3}, 32'h0);
      rst_n = 1'b1;

      run(1'b0, 25'h003, 25'h018, 0, cyc);
      check("win_lat", cyc, 2);
      check("win_move", {23'd0, mv3}, 32'h004);
      check("win_next", {23'd0, nb3}, 32'h007);
      check("win_strat", {30'd0, st3}, 32'd1);
      check("win_busy_bad", {30'd0, busy3, bi3}, 32'd0);
      @(negedge clk);
      check("done_pulse", {31'd0, done3}, 32'd0);

      run(1'b0, 25'h001, 25'h090, 5, cyc);
      check("blk_lat", cyc, 14);
      check("blk_move", {23'd0, mv3}, 32'h002);
      check("blk_next", {23'd0, nb3}, 32'h003);
      check("blk_strat", {30'd0, st3}, 32'd2);

      run(1'b0, 25'h000, 25'h000, 0, cyc);
      check("emp_lat", cyc, 18);
      check("emp_move", {23'd0, mv3}, 32'h010);
      check("emp_strat", {30'd0, st3}, 32'd3);

      run(1'b0, 25'h000, 25'h010, 0, cyc);
      check("corner_move", {23'd0, mv3}, 32'h001);
      check("corner_next", {23'd0, nb3}, 32'h001);

      run(1'b0, 25'h101, 25'h054, 0, cyc);
      check("lowfree_lat", cyc, 18);
      check("lowfree_move", {23'd0, mv3}, 32'h002);
      check("lowfree_strat", {30'd0, st3}, 32'd3);

      run(1'b0, 25'h18D, 25'h072, 0, cyc);
      check("full_lat", cyc, 18);
      check("full_move", {23'd0, mv3}, 32'h000);
      check("full_strat", {30'd0, st3}, 32'd0);
      check("full_nomove", {31'd0, nm3}, 32'd1);
      check("full_next", {23'd0, nb3}, 32'h18D);

      run(1'b0, 25'h001, 25'h001, 0, cyc);
      check("bad_lat", cyc, 1);
      check("bad_flag", {31'd0, bi3}, 32'd1);
      check("bad_move", {23'd0, mv3}, 32'h000);
      check("bad_strat", {30'd0, st3}, 32'd0);

      run(1'b1, 25'h0001041, 25'h0, 0, cyc);
      check("n5_lat", cyc, 22);
      check("n5_move", {7'd0, mv5}, 32'h0040000);
      check("n5_strat", {30'd0, st5}, 32'd1);
      check("n5_next", {7'd0, nb5}, 32'h0041041);

      // Abort a scan with reset, then confirm no done and clean outputs.
      @(negedge clk);
      x3 = 9'h001; o3 = 9'h090; start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("abort_busy_pre", {31'd0, busy3}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_next", {23'd0, nb3}, 32'h0);
      check("abort_flags", {26'd0, st3, nm3, bi3, done3, busy3}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done3) dcount++;
      end
      check("abort_nodone", dcount, 0);

      run(1'b0, 25'h003, 25'h018, 0, cyc);
      check("reuse_lat", cyc, 2);
      check("reuse_move", {23'd0, mv3}, 32'h004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ttt_seq_engine.md
# ttt_seq_engine

Parametrised, clocked successor to the combinational tic-tac-toe move generator. It plays X on an N×N board where K-in-a-row wins, and takes one start/done transaction per move. It scans candidate lines one per cycle in priority order (win, block, then preferred empty cell). It returns a one-hot move, the updated X board and the strategy used. It sits between the board-state registers and the game controller.

## Interface
Parameters:
- N, default 3: board dimension. Legal range 3..8. Cell index = row*N + col.
- K, default 3: run length that wins. Legal range 3..N.

Ports:
- clk  input  1: sole clock, rising edge.
- rst_n  input  1: reset, asynchronous assert, active-low.
- start  input  1: request a move. Sampled only in IDLE.
- xin  input  N*N: current X cells.
- oin  input  N*N: current O cells.
- busy  output  1: high from the cycle after start is accepted through DONE.
- done  output  1: one-cycle pulse, result valid.
- move  output  N*N: one-hot chosen cell, or 0.
- next_board  output  N*N: xin | move.
- strategy  output  2: 0 NONE, 1 WIN, 2 BLOCK, 3 EMPTY.
- no_move  output  1: board full, no legal move.
- bad_input  output  1: xin & oin was non-zero at capture.

## Operation
- FSM states: IDLE → SCAN_WIN → SCAN_BLOCK → SCAN_EMPTY → DONE → IDLE.
- start high in IDLE: capture xin/oin into registers, clear the result, set window index to 0.
- If (xin & oin) != 0 at capture: go straight to DONE with strategy NONE, move 0, bad_input 1.
- Window count L = 2·N·(N−K+1) + 2·(N−K+1)². Windows are enumerated in this order:
  - horizontals (stride 1), then verticals (stride N), then diagonals (stride N+1), then anti-diagonals (stride N−1).
  - Start cells within each direction are row-major.
  - Anti-diagonal starts satisfy col ≥ K−1.
- One window is evaluated per cycle.
  - SCAN_WIN hit: window has K−1 X, 0 O, exactly 1 empty.
  - SCAN_BLOCK hit: the same test with X and O swapped.
- First hit: move = that empty cell, record the strategy, jump to DONE.
- No hit after window L−1: advance to the next state with index 0.
- SCAN_EMPTY takes one cycle. Cell priority is:
  - centre (N odd only),
  - then corners 0, N−1, N²−N, N²−1,
  - then lowest free index.
- No free cell in SCAN_EMPTY: strategy NONE, no_move 1.
- DONE: done pulses high, then the FSM returns to IDLE.
- move, next_board, strategy, no_move and bad_input hold until the next accepted start.
- A board already containing K X needs no special case: its windows have no empty cell, so they never hit.

## Timing
- Reset values: all outputs 0, FSM in IDLE, index 0.
- Reset mid-scan returns to IDLE immediately. No done is emitted.
- start is ignored while busy. No queueing.
- start asserted in the same cycle as DONE is ignored. It is accepted the following IDLE cycle.
- Latency, with the start-sampling edge at cycle 0:
  - WIN hit at window w: done at cycle w+2.
  - BLOCK hit at window w: done at cycle L+w+2.
  - EMPTY or NONE: done at cycle 2L+2.
  - bad_input: done at cycle 1.
- Worst case for N=3 (L=8) is done at cycle 18.
- Window index width = $clog2(L). Per-window X/O counts are $clog2(K+1) bits.

## Structure
- Package ttt_pkg holds:
  - strategy_e (NONE/WIN/BLOCK/EMPTY, 2-bit),
  - state_e,
  - function win_count(N,K) returning L,
  - function window_cell(N,K,idx,j) returning the cell index.
- Sub-module ttt_window_eval (combinational) takes the K gathered X/O bits and returns hit_x, hit_o and the empty position j.
- The top module keeps the FSM, the index counter, the captured boards and the empty-priority encoder.

## Test plan
- N=3: xin=9'h003, oin=9'h018, start → done at cycle 2, move=9'h004, strategy WIN, next_board=9'h007.
- N=3: xin=9'h001, oin=9'h090 → no X win; block on column 1 (window 4) → done at cycle 14, move=9'h002, strategy BLOCK.
- N=3: empty board → done at cycle 18, move=9'h010, strategy EMPTY. Full draw board → done at cycle 18, move=0, strategy NONE, no_move=1.
- N=5, K=4: xin has cells 0, 6, 12, oin=0 → diagonal window 20 → done at cycle 22, move=cell 18.
- xin=9'h001, oin=9'h001 → done at cycle 1, bad_input=1, move=0.
- Abort and re-use:
  - Assert rst_n low at cycle 5 of a scan → outputs 0 and no done.
  - Pulse start while busy → ignored; the first result is unchanged.
